layer_serializer: RTL and testbench
===================================

# layer_serializer

Parallel-to-serial bridge between two neural network layers. It captures the `NN` per-neuron results and per-neuron valid pulses that one layer produces, then replays them as a one-word-per-cycle `x_valid`/`x_in` stream for the next layer's shared input bus. Neuron index 0 is sent first. There is no backpressure in either direction, matching the neuron input protocol.

## Interface
- `NN`, 30: neurons in the upstream layer; number of words per frame.
- `dataWidth`, 16: bits per neuron output.
- `clk` input 1: the only clock; all logic is on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `i_valid` input NN: per-neuron valid pulses from the upstream layer. Bit k is a one-cycle pulse.
- `i_data` input NN*dataWidth: per-neuron outputs. Neuron k occupies bits `[k*dataWidth +: dataWidth]`.
- `o_valid` output 1: stream valid, drives the downstream layer's `x_valid`.
- `o_data` output dataWidth: stream word, drives the downstream layer's `x_in`.
- `o_last` output 1: high together with `o_valid` on word NN-1.
- `busy` output 1: high while in state SEND.
- `overflow` output 1: sticky error flag; cleared only by `rst`.

## Operation
- Primary bank: `NN` data registers plus an NN-bit `got` mask.
- IDLE, per-lane capture:
  - When `i_valid[k]` is high, the bank stores lane k of `i_data` and sets `got[k]`.
  - Lanes may arrive in any order and at any skew.
  - A pulse on a lane whose `got[k]` is already set overwrites that lane's data and sets `overflow`.
- IDLE to SEND:
  - Transition on the clock edge where `got`, including any bits set on that same edge, becomes all ones.
  - On that edge: `got` clears and the word counter loads 0.
- SEND:
  - Each cycle emits `o_data` = bank[cnt] with `o_valid` = 1; `cnt` increments.
  - At cnt = NN-1: `o_last` = 1 and the next state is IDLE, unless the skid path (see Configuration) restarts.
- Pulses during SEND without the skid buffer: the data is dropped and `overflow` is set.
- The counter width is `$clog2(NN)`, minimum 1. The counter never wraps past NN-1.
- Outputs are registered. `o_data` holds its last value when `o_valid` = 0; consumers must ignore it.
- Reset, at any time including mid-SEND:
  - State returns to IDLE; `got`, `cnt`, `o_valid`, `o_last`, `busy` and `overflow` all go to 0; `o_data` goes to 0.
  - A partially sent frame is abandoned; no further words are emitted.

## Timing
- Frame latency: last lane captured on edge t gives word 0 on `o_valid` during cycle t+1 (registered, one cycle).
- Words 0..NN-1 appear in NN consecutive cycles with no gaps.
- `o_last` is high for exactly one cycle per frame.
- `busy` rises together with word 0 and falls in the cycle after `o_last`.
- Simultaneous events:
  - All NN lanes pulsing on the same edge is a complete frame in one cycle.
  - A pulse arriving in the same cycle as `o_last` (state still SEND) counts as "during SEND".
- Minimum frame-to-frame spacing without the skid buffer: NN+1 cycles from the first capture.

## Configuration
- Macro: `LAYER_SERIALIZER_SKID_EN`.
- Defined: a shadow bank with its own `got` mask is added.
  - Pulses during SEND are captured into the shadow bank.
  - A duplicate lane in the shadow bank overwrites that lane and sets `overflow`.
  - On the `o_last` cycle, shadow data and mask transfer to the primary bank, and the shadow mask clears.
  - If the transferred mask, plus any pulses on that edge, is all ones, SEND restarts at cnt = 0. Word 0 of frame N+1 follows word NN-1 of frame N with zero gap cycles.
  - Otherwise the state goes to IDLE with the partial mask preserved.
- Undefined: no shadow bank; pulses during SEND are dropped and `overflow` is set. No shadow registers are synthesised.

## Test plan
- Aligned frame: NN=4, dataWidth=16, all `i_valid` = 4'b1111 with data {0x0004,0x0003,0x0002,0x0001} (lane 3 down to lane 0) on edge t. Required: `o_data` = 1,2,3,4 in cycles t+1..t+4; `o_last` only at t+4; `busy` = 0 at t+5; `overflow` = 0.
- Skewed lanes: pulse lanes 2,0,3,1 on separate cycles with data 0x0A+k. Required: stream starts one cycle after the lane 1 pulse with 0x0A,0x0B,0x0C,0x0D.
- Duplicate lane: pulse lane 1 twice (0x0011, then 0x0022) before the frame completes. Required: word 1 = 0x0022 and `overflow` = 1.
- Back-to-back frames: second full frame arrives while the first is being sent.
  - Without the macro: second frame dropped, `overflow` = 1, only 4 words out.
  - With `LAYER_SERIALIZER_SKID_EN`: 8 contiguous words, `o_last` pulses twice, `overflow` = 0.
- Mid-send reset: assert `rst` during word 2. Required: all outputs 0 in the next cycle, and a fresh frame afterwards serializes correctly.
- Parameter sweep: NN=1 (`o_last` on every word) and NN=30 at dataWidth=16. Required: 30 contiguous words matching lane order.

Source files
------------

// File: rtl/layer_serializer.sv
// layer_serializer: captures NN per-neuron results (any order, any skew) and
// replays them as a one-word-per-cycle valid/data stream, lane 0 first.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   i_valid   [NN]            per-lane capture pulses
//   i_data    [NN*dataWidth]  lane k at [k*dataWidth +: dataWidth]
//   o_valid   stream word valid (registered)
//   o_data    stream word (registered, holds when o_valid is low)
//   o_last    marks word NN-1 (registered)
//   busy      high while sending (registered)
//   overflow  sticky: duplicate lane or dropped pulse; cleared by rst only
//
// Optional feature: define LAYER_SERIALIZER_SKID_EN to add a shadow bank that
// captures the next frame while the current one is being sent, allowing
// back-to-back frames with no gap cycles.
module layer_serializer #(
  parameter int unsigned NN        = 30,
  parameter int unsigned dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_valid,
  output logic [dataWidth-1:0]    o_data,
  output logic                    o_last,
  output logic                    busy,
  output logic                    overflow
);

  localparam int unsigned CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);
  localparam logic [NN-1:0] ALL_ONES = '1;

  typedef enum logic {S_IDLE, S_SEND} state_e;
  typedef logic [NN-1:0][dataWidth-1:0] bank_t;

  state_e                state_q, state_d;
  bank_t                 bank_q, bank_d;
  logic [NN-1:0]         got_q, got_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  o_valid_q, o_valid_d;
  logic [dataWidth-1:0]  o_data_q, o_data_d;
  logic                  o_last_q, o_last_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;
`ifdef LAYER_SERIALIZER_SKID_EN
  bank_t                 shadow_q, shadow_d;
  logic [NN-1:0]         sgot_q, sgot_d;
`endif

  bank_t         lanes_c;
  logic [CW-1:0] cnt_inc_c;
  logic          start_c;

  assign lanes_c = bank_t'(i_data);

  // Next-state, capture and output computation.
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    got_d      = got_q;
    cnt_d      = cnt_q;
    o_valid_d  = 1'b0;
    o_data_d   = o_data_q;
    o_last_d   = 1'b0;
    busy_d     = busy_q;
    overflow_d = overflow_q;
`ifdef LAYER_SERIALIZER_SKID_EN
    shadow_d   = shadow_q;
    sgot_d     = sgot_q;
`endif
    cnt_inc_c  = cnt_q + CW'(1);
    start_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        for (int k = 0; k < NN; k++) begin
          if (i_valid[k]) begin
            bank_d[k] = lanes_c[k];
            got_d[k]  = 1'b1;
            if (got_q[k]) overflow_d = 1'b1;
          end
        end
        // Lanes landing on this edge count toward completion.
        if (got_d == ALL_ONES) start_c = 1'b1;
      end

      S_SEND: begin
`ifdef LAYER_SERIALIZER_SKID_EN
        for (int k = 0; k < NN; k++) begin
          if (i_valid[k]) begin
            shadow_d[k] = lanes_c[k];
            sgot_d[k]   = 1'b1;
            if (sgot_q[k]) overflow_d = 1'b1;
          end
        end
`else
        if (|i_valid) overflow_d = 1'b1;
`endif
        // cnt_q indexes the word currently on the output.
        if (cnt_q == LAST_IDX) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
`ifdef LAYER_SERIALIZER_SKID_EN
          // Hand the shadow frame to the primary bank; restart if complete.
          bank_d = shadow_d;
          got_d  = sgot_d;
          sgot_d = '0;
          if (got_d == ALL_ONES) start_c = 1'b1;
`endif
        end else begin
          cnt_d     = cnt_inc_c;
          o_valid_d = 1'b1;
          o_data_d  = bank_q[cnt_inc_c];
          o_last_d  = (cnt_inc_c == LAST_IDX);
        end
      end
    endcase

    // Frame start: word 0 goes out registered on the same edge.
    if (start_c) begin
      state_d   = S_SEND;
      got_d     = '0;
      cnt_d     = '0;
      o_valid_d = 1'b1;
      o_data_d  = bank_d[0];
      o_last_d  = (NN == 1);
      busy_d    = 1'b1;
    end
  end

  // State and output registers; data banks need no reset.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
`ifdef LAYER_SERIALIZER_SKID_EN
    shadow_q <= shadow_d;
`endif
    if (rst) begin
      state_q    <= S_IDLE;
      got_q      <= '0;
      cnt_q      <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef LAYER_SERIALIZER_SKID_EN
      sgot_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      got_q      <= got_d;
      cnt_q      <= cnt_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_last_q   <= o_last_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef LAYER_SERIALIZER_SKID_EN
      sgot_q     <= sgot_d;
`endif
    end
  end

  assign o_valid  = o_valid_q;
  assign o_data   = o_data_q;
  assign o_last   = o_last_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: NN=4, NN=1 and NN=30 instances, scoreboard
// queues of expected {data, last, cycle} popped by per-instance monitors.
module tb_layer_serializer;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   base;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q30[$];

  // NN=4
  logic [3:0]   i_valid4 = '0;
  logic [63:0]  i_data4  = '0;
  logic         o_valid4, o_last4, busy4, overflow4;
  logic [15:0]  o_data4;
  // NN=1
  logic [0:0]   i_valid1 = '0;
  logic [15:0]  i_data1  = '0;
  logic         o_valid1, o_last1, busy1, overflow1;
  logic [15:0]  o_data1;
  // NN=30
  logic [29:0]  i_valid30 = '0;
  logic [479:0] i_data30  = '0;
  logic         o_valid30, o_last30, busy30, overflow30;
  logic [15:0]  o_data30;

  layer_serializer #(.NN(4), .dataWidth(16)) u4 (
    .clk(clk), .rst(rst), .i_valid(i_valid4), .i_data(i_data4),
    .o_valid(o_valid4), .o_data(o_data4), .o_last(o_last4),
    .busy(busy4), .overflow(overflow4));

  layer_serializer #(.NN(1), .dataWidth(16)) u1 (
    .clk(clk), .rst(rst), .i_valid(i_valid1), .i_data(i_data1),
    .o_valid(o_valid1), .o_data(o_data1), .o_last(o_last1),
    .busy(busy1), .overflow(overflow1));

  layer_serializer #(.NN(30), .dataWidth(16)) u30 (
    .clk(clk), .rst(rst), .i_valid(i_valid30), .i_data(i_data30),
    .o_valid(o_valid30), .o_data(o_data30), .o_last(o_last30),
    .busy(busy30), .overflow(overflow30));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push n words of a 4-lane frame; word k expected in cycle first+k.
  task automatic push4(input logic [63:0] words, input int first, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = words[k*16 +: 16];
      e.last = (k == 3);
      e.cyc  = first + k;
      q4.push_back(e);
    end
  endtask

  always @(negedge clk) begin : mon4
    exp_t e;
    if (o_valid4) begin
      if (q4.size() == 0) check("u4_unexpected_word", 64'(o_valid4), 64'd0);
      else begin
        e = q4.pop_front();
        check("u4_data", 64'(o_data4), 64'(e.data));
        check("u4_last", 64'(o_last4), 64'(e.last));
        check("u4_cycle", 64'(cyc), 64'(e.cyc));
        check("u4_busy", 64'(busy4), 64'd1);
      end
    end else begin
      check("u4_last_idle", 64'(o_last4), 64'd0);
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (o_valid1) begin
      if (q1.size() == 0) check("u1_unexpected_word", 64'(o_valid1), 64'd0);
      else begin
        e = q1.pop_front();
        check("u1_data", 64'(o_data1), 64'(e.data));
        check("u1_last", 64'(o_last1), 64'(e.last));
        check("u1_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon30
    exp_t e;
    if (o_valid30) begin
      if (q30.size() == 0) check("u30_unexpected_word", 64'(o_valid30), 64'd0);
      else begin
        e = q30.pop_front();
        check("u30_data", 64'(o_data30), 64'(e.data));
        check("u30_last", 64'(o_last30), 64'(e.last));
        check("u30_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    exp_t e;
    logic [15:0] w;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_o_valid", 64'(o_valid4), 64'd0);
    check("rst_o_last", 64'(o_last4), 64'd0);
    check("rst_busy", 64'(busy4), 64'd0);
    check("rst_overflow", 64'(overflow4), 64'd0);
    check("rst_o_data", 64'(o_data4), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Aligned frame
    @(negedge clk);
    i_valid4 = 4'b1111; i_data4 = 64'h0004_0003_0002_0001; base = cyc;
    push4(64'h0004_0003_0002_0001, base + 1, 4);
    @(negedge clk); i_valid4 = '0;
    repeat (4) @(negedge clk);
    check("aligned_busy_after", 64'(busy4), 64'd0);
    check("aligned_overflow", 64'(overflow4), 64'd0);
    repeat (3) @(negedge clk);

    // Skewed lanes 2,0,3,1
    i_data4 = 64'h000D_000C_000B_000A;
    @(negedge clk); i_valid4 = 4'b0100;
    @(negedge clk); i_valid4 = 4'b0001;
    @(negedge clk); i_valid4 = 4'b1000;
    @(negedge clk); i_valid4 = 4'b0010; base = cyc;
    push4(64'h000D_000C_000B_000A, base + 1, 4);
    @(negedge clk); i_valid4 = '0;
    repeat (6) @(negedge clk);
    check("skew_overflow", 64'(overflow4), 64'd0);

    // Duplicate lane 1
    @(negedge clk); i_valid4 = 4'b0010; i_data4 = 64'h0000_0000_0011_0000;
    @(negedge clk); i_valid4 = 4'b0010; i_data4 = 64'h0000_0000_0022_0000;
    @(negedge clk); i_valid4 = 4'b1101; i_data4 = 64'h0033_0032_0000_0030; base = cyc;
    push4(64'h0033_0032_0022_0030, base + 1, 4);
    @(negedge clk); i_valid4 = '0;
    repeat (6) @(negedge clk);
    check("dup_overflow", 64'(overflow4), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("dup_overflow_cleared", 64'(overflow4), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back frames
    @(negedge clk);
    i_valid4 = 4'b1111; i_data4 = 64'h0044_0043_0042_0041; base = cyc;
    push4(64'h0044_0043_0042_0041, base + 1, 4);
    @(negedge clk);
    i_data4 = 64'h0048_0047_0046_0045;
`ifdef LAYER_SERIALIZER_SKID_EN
    push4(64'h0048_0047_0046_0045, base + 5, 4);
`endif
    @(negedge clk); i_valid4 = '0;
    repeat (10) @(negedge clk);
`ifdef LAYER_SERIALIZER_SKID_EN
    check("b2b_overflow", 64'(overflow4), 64'd0);
`else
    check("b2b_overflow", 64'(overflow4), 64'd1);
`endif
    check("b2b_busy_after", 64'(busy4), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mid-send reset during word 2
    @(negedge clk);
    i_valid4 = 4'b1111; i_data4 = 64'h0054_0053_0052_0051; base = cyc;
    push4(64'h0054_0053_0052_0051, base + 1, 3);
    @(negedge clk); i_valid4 = '0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_o_valid", 64'(o_valid4), 64'd0);
    check("midrst_o_last", 64'(o_last4), 64'd0);
    check("midrst_busy", 64'(busy4), 64'd0);
    check("midrst_overflow", 64'(overflow4), 64'd0);
    check("midrst_o_data", 64'(o_data4), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_resume", 64'(o_valid4), 64'd0);
    @(negedge clk);
    i_valid4 = 4'b1111; i_data4 = 64'h0064_0063_0062_0061; base = cyc;
    push4(64'h0064_0063_0062_0061, base + 1, 4);
    @(negedge clk); i_valid4 = '0;
    repeat (6) @(negedge clk);

    // NN=1: every word is last
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      i_valid1 = 1'b1; i_data1 = 16'(16'h0071 + f);
      e.data = i_data1; e.last = 1'b1; e.cyc = cyc + 1;
      q1.push_back(e);
      @(negedge clk); i_valid1 = '0;
    end
    repeat (4) @(negedge clk);
    check("nn1_overflow", 64'(overflow1), 64'd0);

    // NN=30: even lanes, then odd lanes completing the frame
    for (int k = 0; k < 30; k++) i_data30[k*16 +: 16] = 16'(16'h0100 + 3 * k);
    @(negedge clk);
    for (int k = 0; k < 30; k++) i_valid30[k] = (k % 2 == 0);
    @(negedge clk);
    for (int k = 0; k < 30; k++) i_valid30[k] = (k % 2 == 1);
    base = cyc;
    for (int k = 0; k < 30; k++) begin
      w = 16'(16'h0100 + 3 * k);
      e.data = w; e.last = (k == 29); e.cyc = base + 1 + k;
      q30.push_back(e);
    end
    @(negedge clk); i_valid30 = '0;
    repeat (35) @(negedge clk);
    check("nn30_overflow", 64'(overflow30), 64'd0);
    check("nn30_busy_after", 64'(busy30), 64'd0);

    // All expected words must have been produced
    check("drain_u4", 64'(q4.size()), 64'd0);
    check("drain_u1", 64'(q1.size()), 64'd0);
    check("drain_u30", 64'(q30.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
